// File: rtl/stump_fetch_unit_pkg.sv
// stump_fetch_unit_pkg: shared Stump fetch definitions (word width, reset PC, FSM encodings)
package stump_fetch_unit_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        ERR  = 2'b10
    } fetch_state_e;
endpackage

// File: rtl/stump_fetch_unit_timer.sv
// stump_fetch_timer: request timeout counter; expired fires on the edge the count would reach TIMEOUT_CYCLES
module stump_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count_q, count_d;
    always_comb begin
        count_d = clear ? 8'd0 : enable ? count_q + 8'd1 : count_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= 8'd0;
        else      count_q <= count_d;
    end
    assign expired = enable && (count_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/stump_fetch_unit.sv
// stump_fetch_unit: Stump PC/IR fetch stage over a req/ack memory port; STUMP_FETCH_TIMEOUT_EN adds a request timeout and ERR state
module stump_fetch_unit
    import stump_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_wen,
    input  logic [15:0] pc_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic        fetch_busy,
    output logic        bus_error
);
    fetch_state_e state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, ir_q, ir_d, mem_addr_q, mem_addr_d;
    logic ir_valid_q, ir_valid_d;
    logic start, done, expired;
    assign start = (state_q == IDLE) && fetch_start;
    assign done  = (state_q == REQ) && mem_ack;
`ifdef STUMP_FETCH_TIMEOUT_EN
    stump_fetch_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  ((state_q == REQ) && !mem_ack),
        .expired (expired)
    );
    assign bus_error = (state_q == ERR);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign expired   = 1'b0;
    assign bus_error = 1'b0;
`endif
    always_comb begin
        state_d    = start ? REQ : done ? IDLE : expired ? ERR : state_q;
        mem_addr_d = start ? pc_q : mem_addr_q;
        ir_d       = done ? mem_rdata : ir_q;
        ir_valid_d = start ? 1'b0 : done ? 1'b1 : ir_valid_q;
        // a redirect wins over the post-fetch increment
        pc_d       = pc_wen ? pc_wdata : done ? pc_q + 16'd1 : pc_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            mem_addr_q <= mem_addr_d;
        end
    end
    assign mem_req    = (state_q == REQ);
    assign fetch_busy = (state_q != IDLE);
    assign mem_addr   = mem_addr_q;
    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign pc         = pc_q;
endmodule
